// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller shared by instruction fetch and load/store.
// One RAM byte per enabled cycle; read bytes return on ram_din one cycle after their address.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  flush_in,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [2:0]            mem_len,
    input  logic [31:0]           mem_wdata,
    output logic                  mem_done,
    output logic [31:0]           mem_rdata,
    input  logic [7:0]            ram_din,
    output logic [7:0]            ram_dout,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_wr
);

    // state | meaning
    // IDLE  | no transaction; accepts a request when no done pulse is showing
    // READ  | addresses bytes 0..N-1, captures byte k-1 each cycle, finishes at k=N
    // WRITE | drives bytes 0..N-1 with ram_wr=1, finishes after k=N-1
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                state_q, state_d;
    logic                  owner_mem_q, owner_mem_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [2:0]            len_q, len_d;
    logic [2:0]            k_q, k_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           result_q, result_d;
    logic                  if_done_q, if_done_d;
    logic                  mem_done_q, mem_done_d;
    logic [2:0]            len_dec;

    // Anything other than 1 or 2 bytes is a word access.
    always_comb begin
        case (mem_len)
            3'd1:    len_dec = 3'd1;
            3'd2:    len_dec = 3'd2;
            default: len_dec = 3'd4;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            owner_mem_q <= 1'b0;
            base_q      <= '0;
            len_q       <= 3'd0;
            k_q         <= 3'd0;
            wdata_q     <= 32'd0;
            result_q    <= 32'd0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_mem_q <= owner_mem_d;
            base_q      <= base_d;
            len_q       <= len_d;
            k_q         <= k_d;
            wdata_q     <= wdata_d;
            result_q    <= result_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        base_d      = base_q;
        len_d       = len_q;
        k_d         = k_q;
        wdata_d     = wdata_q;
        result_d    = result_q;
        if_done_d   = if_done_q;
        mem_done_d  = mem_done_q;
        if (rdy_in) begin
            if_done_d  = 1'b0;
            mem_done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    // Blocking acceptance during a done pulse keeps a held request from re-issuing.
                    if (!if_done_q && !mem_done_q) begin
                        if (mem_req) begin
                            owner_mem_d = 1'b1;
                            base_d      = mem_addr;
                            len_d       = len_dec;
                            wdata_d     = mem_wdata;
                            k_d         = 3'd0;
                            result_d    = 32'd0;
                            state_d     = mem_we ? WRITE : READ;
                        end else if (if_req && !flush_in) begin
                            owner_mem_d = 1'b0;
                            base_d      = if_addr;
                            len_d       = 3'd4;
                            k_d         = 3'd0;
                            result_d    = 32'd0;
                            state_d     = READ;
                        end
                    end
                end
                READ: begin
                    if (!owner_mem_q && flush_in) begin
                        state_d = IDLE;
                        k_d     = 3'd0;
                    end else begin
                        case (k_q)
                            3'd1:    result_d[7:0]   = ram_din;
                            3'd2:    result_d[15:8]  = ram_din;
                            3'd3:    result_d[23:16] = ram_din;
                            3'd4:    result_d[31:24] = ram_din;
                            default: ;
                        endcase
                        if (k_q == len_q) begin
                            state_d = IDLE;
                            k_d     = 3'd0;
                            if (owner_mem_q) mem_done_d = 1'b1;
                            else             if_done_d  = 1'b1;
                        end else begin
                            k_d = k_q + 3'd1;
                        end
                    end
                end
                WRITE: begin
                    if (k_q == len_q - 3'd1) begin
                        state_d    = IDLE;
                        k_d        = 3'd0;
                        mem_done_d = 1'b1;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ram_a    = '0;
        ram_wr   = 1'b0;
        ram_dout = 8'd0;
        if (state_q != IDLE) ram_a = base_q + ADDR_WIDTH'(k_q);
        if (state_q == WRITE) begin
            ram_wr = rdy_in;
            case (k_q[1:0])
                2'd0:    ram_dout = wdata_q[7:0];
                2'd1:    ram_dout = wdata_q[15:8];
                2'd2:    ram_dout = wdata_q[23:16];
                default: ram_dout = wdata_q[31:24];
            endcase
        end
    end

    assign if_done   = if_done_q;
    assign mem_done  = mem_done_q;
    assign if_data   = if_done_q  ? result_q : 32'd0;
    assign mem_rdata = mem_done_q ? result_q : 32'd0;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized transactions against a byte-array reference memory.
// The bench owns a 4 KB RAM model (clocked with rdy_in as system enable) and a separate expected copy.
module tb_mem_ctrl;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        flush_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [2:0]  mem_len;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    logic [7:0]  ram     [0:4095];
    logic [7:0]  ref_mem [0:4095];

    int n_vec = 0;
    int n_err = 0;

    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .flush_in(flush_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
        if (rdy_in) ram_din <= ram[ram_a[11:0]];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] v);
        ram[a[11:0]]     = v;
        ref_mem[a[11:0]] = v;
    endtask

    // Called at a negedge; the following posedge is the acceptance edge.
    task automatic run_txn(input bit is_mem, input bit we, input logic [31:0] addr,
                           input logic [2:0] len, input logic [31:0] wd, input int pmode,
                           input bit keep_if, output logic [31:0] rd);
        int          n, c, kk, pauses, lat;
        bit          seen, is_wr;
        logic [31:0] exp_data, a;
        is_wr = is_mem && we;
        n = !is_mem ? 4 : (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
        exp_data = 32'd0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            if (!is_wr) exp_data[8*i +: 8] = ref_mem[a[11:0]];
        end
        mem_req   = is_mem;
        mem_we    = we;
        mem_len   = len;
        mem_wdata = wd;
        if (is_mem) mem_addr = addr;
        else        if_addr  = addr;
        if_req   = !is_mem || keep_if;
        rdy_in   = 1'b1;
        flush_in = 1'b0;
        @(posedge clk_in);
        c = 0; kk = 0; pauses = 0; seen = 0;
        while (!seen && c < 40) begin
            @(negedge clk_in);
            c++;
            if (is_mem ? mem_done : if_done) begin
                seen = 1;
            end else begin
                rdy_in = (pmode == 0) ? 1'b1 :
                         (pmode == 1) ? ($urandom_range(0, 4) != 0) : !(c >= 2 && c <= 4);
                if (is_mem) flush_in = ($urandom_range(0, 3) == 0);
                #1;
                if (!rdy_in) begin
                    pauses++;
                    chk("pause_wr", {31'd0, ram_wr}, 32'd0);
                    if (kk < n) chk("pause_addr", ram_a, addr + 32'(kk));
                end else begin
                    if (kk < n) begin
                        chk("bus_wr", {31'd0, ram_wr}, {31'd0, is_wr});
                        chk("bus_addr", ram_a, addr + 32'(kk));
                        if (is_wr) chk("bus_dout", {24'd0, ram_dout}, {24'd0, wd[8*kk +: 8]});
                    end
                    kk++;
                end
            end
        end
        rdy_in   = 1'b1;
        flush_in = 1'b0;
        chk("done_seen", {31'd0, seen}, 32'd1);
        lat = (is_wr ? n + 1 : n + 2) + pauses;
        rd = is_mem ? mem_rdata : if_data;
        if (seen) begin
            chk("latency", c, lat);
            chk("other_done", {31'd0, is_mem ? if_done : mem_done}, 32'd0);
            if (!is_wr) chk("rdata", rd, exp_data);
        end
        if (is_wr) begin
            for (int i = 0; i < n; i++) begin
                a = addr + 32'(i);
                ref_mem[a[11:0]] = wd[8*i +: 8];
                chk("ram_byte", {24'd0, ram[a[11:0]]}, {24'd0, ref_mem[a[11:0]]});
            end
        end
        if (is_mem) mem_req = 1'b0;
        else        if_req  = 1'b0;
        @(negedge clk_in);
        chk("done_pulse", {30'd0, if_done, mem_done}, 32'd0);
    endtask

    logic [31:0] rd, ra;
    int          kind;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        rst_in = 1'b1; rdy_in = 1'b1; if_req = 1'b0; if_addr = 32'd0; flush_in = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_len = 3'd0; mem_wdata = 32'd0;
        repeat (2) @(negedge clk_in);
        chk("rst_ram_a", ram_a, 32'd0);
        chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        chk("rst_done", {30'd0, if_done, mem_done}, 32'd0);
        chk("rst_data", if_data | mem_rdata, 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'h10); preload(32'h103, 8'h00);
        run_txn(0, 0, 32'h100, 3'd4, 32'd0, 0, 0, rd);
        chk("fetch_0x100", rd, 32'h00100513);

        preload(32'h7, 8'hF0);
        run_txn(1, 0, 32'h7, 3'd1, 32'd0, 0, 0, rd);
        chk("lb_0x7", rd, 32'h000000F0);

        if_addr = 32'h100;
        run_txn(1, 1, 32'h20, 3'd2, 32'hAABBCCDD, 0, 1, rd);
        run_txn(0, 0, 32'h100, 3'd4, 32'd0, 0, 0, rd);
        chk("fetch_after_st", rd, 32'h00100513);

        run_txn(1, 1, 32'h80, 3'd4, 32'h11223344, 2, 0, rd);
        run_txn(1, 0, 32'h80, 3'd4, 32'd0, 0, 0, rd);
        chk("lw_after_sw", rd, 32'h11223344);

        if_req = 1'b1; if_addr = 32'h300; flush_in = 1'b0; rdy_in = 1'b1;
        @(posedge clk_in);
        repeat (3) @(negedge clk_in);
        chk("flush_k2_addr", ram_a, 32'h302);
        flush_in = 1'b1; if_req = 1'b0;
        @(negedge clk_in);
        chk("flush_idle", ram_a, 32'd0);
        chk("flush_no_done", {31'd0, if_done}, 32'd0);
        if_req = 1'b1; if_addr = 32'h400;
        @(negedge clk_in);
        chk("flush_blocks", ram_a, 32'd0);
        chk("flush_blk_done", {31'd0, if_done}, 32'd0);
        flush_in = 1'b0;
        run_txn(0, 0, 32'h200, 3'd4, 32'd0, 0, 0, rd);

        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40; mem_len = 3'd4;
        @(posedge clk_in);
        repeat (2) @(negedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        chk("midrst_ram_a", ram_a, 32'd0);
        chk("midrst_wr", {31'd0, ram_wr}, 32'd0);
        chk("midrst_done", {30'd0, if_done, mem_done}, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        chk("midrst_nodone", {31'd0, mem_done}, 32'd0);
        run_txn(1, 0, 32'h40, 3'd4, 32'd0, 0, 0, rd);

        run_txn(1, 1, 32'hFFFF_FFFE, 3'd4, 32'hCAFE_BABE, 0, 0, rd);
        run_txn(1, 0, 32'hFFFF_FFFE, 3'd4, 32'd0, 0, 0, rd);
        chk("wrap_lw", rd, 32'hCAFE_BABE);

        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 2);
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFC + 32'($urandom_range(1, 3));
            run_txn(kind != 0, kind == 2, ra, 3'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 1), 0, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of if_addr, mem_addr and ram_a.
REQ-002 clk_in  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 rdy_in  input  1  global enable; low = pause.
REQ-005 if_req  input  1  instruction-fetch request, held until if_done.
REQ-006 if_addr  input  ADDR_WIDTH  fetch address; fetches are always 4 bytes.
REQ-007 if_done  output  1  one-cycle pulse: fetch complete.
REQ-008 if_data  output  32  fetched word, little-endian, valid while if_done=1.
REQ-009 flush_in  input  1  branch/jump redirect; cancels instruction-fetch work.
REQ-010 mem_req  input  1  load/store request, held until mem_done.
REQ-011 mem_we  input  1  1 = store, 0 = load.
REQ-012 mem_addr  input  ADDR_WIDTH  byte address of the load/store.
REQ-013 mem_len  input  3  byte count; legal values 1, 2, 4.
REQ-014 mem_wdata  input  32  store data; low mem_len bytes used.
REQ-015 mem_done  output  1  one-cycle pulse: load/store complete.
REQ-016 mem_rdata  output  32  load data, zero-extended, valid while mem_done=1.
REQ-017 ram_din  input  8  RAM read byte; valid one cycle after its address.
REQ-018 ram_dout  output  8  RAM write byte.
REQ-019 ram_a  output  ADDR_WIDTH  RAM byte address.
REQ-020 ram_wr  output  1  1 = write, 0 = read.

Function
REQ-021 States: IDLE, READ, WRITE. Latched values: owner (IF/MEM), base address, length N, write data, byte index k.
REQ-022 Acceptance: an edge in IDLE with rdy_in=1, if_done=0, mem_done=0 and a pending request latches that request.
- mem_req=1: owner=MEM, N=mem_len; mem_we=1 -> WRITE, else READ.
- Otherwise if_req=1 and flush_in=0: owner=IF, N=4, READ.
- k=0 on entry.
REQ-023 Priority: when mem_req and if_req are both high at acceptance, MEM wins.
REQ-024 READ, cycle with index k:
- Address phase (k<N): ram_a=base+k, ram_wr=0.
- Capture (k>=1): byte k-1 from ram_din stored in result bits [8(k-1)+7 : 8(k-1)].
- k increments each enabled edge.
REQ-025 READ termination: the edge ending cycle k=N captures the last byte, returns to IDLE, and registers the owner's done=1 with assembled data; unused upper bytes are 0.
REQ-026 WRITE, cycle with index k (k<N): ram_a=base+k, ram_wr=1, ram_dout=wdata byte k; after k=N-1 return to IDLE with mem_done=1.
REQ-027 Latency from acceptance edge E0:
- LW / fetch: done high in cycle 6 (bus cycles 1-5).
- LB: done high in cycle 3.
- SW: done high in cycle 5.
- SB: done high in cycle 2.
REQ-028 Done pulses last exactly one cycle; if_done and mem_done are never high together; no acceptance occurs in a done cycle, so a stale held request is not re-accepted.
REQ-029 IDLE outputs: ram_wr=0, ram_a=0, ram_dout=0.
REQ-030 Pause: rdy_in=0 freezes all state, counters and the done register, and forces ram_wr=0; ram_a holds its value.
REQ-031 Flush with owner=IF in READ: next edge returns to IDLE, if_done is not raised and partial data is discarded; flush_in=1 in IDLE blocks IF acceptance that cycle.
REQ-032 flush_in has no effect on a MEM transaction or on a mem_done pulse.
REQ-033 Address arithmetic base+k wraps modulo 2^ADDR_WIDTH.
REQ-034 Illegal mem_len (0, 3, 5-7) is treated as 4.

Reset
REQ-035 rst_in=1 asynchronously forces IDLE, k=0, all outputs 0 and latched data 0.
REQ-036 Reset mid-transaction abandons it with no done pulse; after release the controller is IDLE and accepts a held request normally.

Verification
REQ-037 RAM[0x100..0x103]=0x13,0x05,0x10,0x00; if_req with if_addr=0x100 -> ram_a 0x100-0x103, if_done in cycle 6, if_data=0x00100513.
REQ-038 mem_req and if_req raised together; mem_we=1, mem_addr=0x20, len=2, wdata=0xAABBCCDD -> bytes 0xDD@0x20, 0xCC@0x21, mem_done in cycle 3, then the IF fetch starts.
REQ-039 LB at 0x7 where RAM[0x7]=0xF0 -> mem_rdata=0x000000F0 in cycle 3.
REQ-040 Fetch in progress, flush_in=1 at k=2 -> IDLE next cycle, no if_done; a new fetch to 0x200 completes 6 cycles after acceptance.
REQ-041 rdy_in=0 for 3 cycles during SW -> ram_wr=0 while paused; total latency 5+3 cycles; RAM contents correct.
REQ-042 rst_in pulsed mid-LW -> outputs 0 immediately, no mem_done; held mem_req re-accepted after release and completes correctly.
